mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a shared data-memory port: alternating priority with a bounded bus lock.
// Grants are combinational; read data returns one cycle after the accepted read.
module mem_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        reset,
    // CPU port
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    // DMA / loader port
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    // shared memory port
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rv0;
    logic          r_rv1;

    logic          w_lock0;
    logic          w_lock1;
    logic          w_g0;
    logic          w_g1;
    logic [CW-1:0] w_cnt_inc;

    assign w_lock0 = (r_state == OWN0) && m0_req && m0_lock && (r_lock_cnt < CW'(MAX_LOCK));
    assign w_lock1 = (r_state == OWN1) && m1_req && m1_lock && (r_lock_cnt < CW'(MAX_LOCK));
    assign w_cnt_inc = (r_lock_cnt == CW'(MAX_LOCK)) ? r_lock_cnt : r_lock_cnt + CW'(1);

    // Grants are held off while reset is asserted so nothing is accepted then.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (reset) begin
            if (w_lock0) begin
                w_g0 = 1'b1;
            end else if (w_lock1) begin
                w_g1 = 1'b1;
            end else if (m0_req && m1_req) begin
                w_g0 = r_last;
                w_g1 = ~r_last;
            end else begin
                w_g0 = m0_req;
                w_g1 = m1_req;
            end
        end
    end

    // The acquiring grant counts as the first locked grant, so an owner keeps at most MAX_LOCK in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            r_rv0      <= 1'b0;
            r_rv1      <= 1'b0;
        end else begin
            r_rv0 <= w_g0 & ~m0_we;
            r_rv1 <= w_g1 & ~m1_we;
            if (w_g0) begin
                r_state <= OWN0;
                r_last  <= 1'b0;
                if (m1_req && m0_lock)
                    r_lock_cnt <= (r_state == OWN0) ? w_cnt_inc : CW'(1);
                else
                    r_lock_cnt <= '0;
            end else if (w_g1) begin
                r_state <= OWN1;
                r_last  <= 1'b1;
                if (m0_req && m1_lock)
                    r_lock_cnt <= (r_state == OWN1) ? w_cnt_inc : CW'(1);
                else
                    r_lock_cnt <= '0;
            end else begin
                r_state    <= IDLE;
                r_lock_cnt <= '0;
            end
        end
    end

    assign m0_gnt    = w_g0;
    assign m1_gnt    = w_g1;
    assign m0_rvalid = r_rv0 & reset;
    assign m1_rvalid = r_rv1 & reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

    assign mem_we    = (w_g0 & m0_we) | (w_g1 & m1_we);
    assign mem_addr  = w_g0 ? m0_addr  : (w_g1 ? m1_addr  : 32'h0);
    assign mem_wdata = w_g0 ? m0_wdata : (w_g1 ? m1_wdata : 32'h0);
    assign mem_wmask = w_g0 ? m0_wmask : (w_g1 ? m1_wmask : 4'h0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Vector/scoreboard bench for mem_arbiter: expected grants come from hand-derived tables,
// expected rvalid is queued from those grants and checked one cycle later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_LOCK(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          rst;
        bit          r0, w0, l0;
        logic [31:0] a0, d0;
        logic [3:0]  k0;
        bit          r1, w1, l1;
        logic [31:0] a1, d1;
        logic [3:0]  k1;
        bit          g0, g1;
    } vec_t;

    typedef struct {
        bit rv0;
        bit rv1;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(bit rst, bit r0, bit w0, bit l0,
                                bit r1, bit w1, bit l1, bit g0, bit g1);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.w0 = w0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1;
        v.a0 = $urandom; v.d0 = $urandom; v.k0 = 4'($urandom);
        v.a1 = $urandom; v.d1 = $urandom; v.k1 = 4'($urandom);
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        sb_t         e;
        logic [31:0] ea, ed;
        logic [3:0]  ek;
        logic        ew;
        reset   = v.rst;
        m0_req  = v.r0; m0_we = v.w0; m0_lock = v.l0;
        m0_addr = v.a0; m0_wdata = v.d0; m0_wmask = v.k0;
        m1_req  = v.r1; m1_we = v.w1; m1_lock = v.l1;
        m1_addr = v.a1; m1_wdata = v.d1; m1_wmask = v.k1;
        mem_rdata = $urandom;
        @(negedge clk);
        if (v.g0) begin
            ea = v.a0; ed = v.d0; ek = v.k0; ew = v.w0;
        end else if (v.g1) begin
            ea = v.a1; ed = v.d1; ek = v.k1; ew = v.w1;
        end else begin
            ea = '0; ed = '0; ek = '0; ew = 1'b0;
        end
        chk({tag, " m0_gnt"},    32'(m0_gnt),    32'(v.g0));
        chk({tag, " m1_gnt"},    32'(m1_gnt),    32'(v.g1));
        chk({tag, " gnt_excl"},  32'(m0_gnt & m1_gnt), 32'h0);
        chk({tag, " mem_we"},    32'(mem_we),    32'(ew));
        chk({tag, " mem_addr"},  mem_addr,       ea);
        chk({tag, " mem_wdata"}, mem_wdata,      ed);
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(ek));
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
            e.rv0 = 1'b0;
            e.rv1 = 1'b0;
        end else begin
            e = sbq.pop_front();
        end
        // rvalid is suppressed while reset is asserted
        e.rv0 = e.rv0 & v.rst;
        e.rv1 = e.rv1 & v.rst;
        chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(e.rv0));
        chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(e.rv1));
        chk({tag, " m0_rdata"},  m0_rdata, e.rv0 ? mem_rdata : 32'h0);
        chk({tag, " m1_rdata"},  m1_rdata, e.rv1 ? mem_rdata : 32'h0);
        e.rv0 = v.g0 & ~v.w0;
        e.rv1 = v.g1 & ~v.w1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
        mem_rdata = 0;
        sbq.push_back('{rv0: 1'b0, rv1: 1'b0});

        //                rst r0 w0 l0 r1 w1 l1 g0 g1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));   // reset, idle
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));   // reads during reset not accepted
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0));   // first tie goes to m0
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1));
        v = mk(1, 1, 1, 0, 0, 0, 0, 1, 0);               // m0 full-word write
        v.a0 = 32'h104; v.d0 = 32'h3FF; v.k0 = 4'hF;
        tbl.push_back(v);
        v = mk(1, 0, 0, 0, 1, 1, 0, 0, 1);               // m1 byte write
        v.a1 = 32'h20; v.k1 = 4'b0010;
        tbl.push_back(v);
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); // idle
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // lock starvation guard: m1 keeps 8 grants, m0 gets one, m1 regains
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 0), "lk_m0");
        for (int i = 0; i < 8; i++)
            step(mk(1, 1, 0, 0, 1, 0, 1, 0, 1), $sformatf("lk_m1_%0d", i));
        step(mk(1, 1, 0, 0, 1, 0, 1, 1, 0), "lk_guard");
        step(mk(1, 1, 0, 0, 1, 0, 1, 0, 1), "lk_regain");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "lk_idle");

        // m0 lock holds against m1, m1 drops req while waiting, then lock released
        step(mk(1, 1, 0, 1, 0, 0, 0, 1, 0), "hold_a");
        step(mk(1, 1, 0, 1, 1, 0, 0, 1, 0), "hold_b");
        step(mk(1, 1, 0, 1, 0, 0, 0, 1, 0), "hold_drop");
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 1), "hold_rel");

        // reset while a read is outstanding; tie priority returns to m0
        step(mk(1, 1, 0, 0, 0, 0, 0, 1, 0), "rmr_rd");
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), "rmr_rst");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rmr_after");
        step(mk(1, 1, 0, 0, 1, 0, 0, 1, 0), "rmr_tie0");
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 1), "rmr_tie1");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rmr_end0");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rmr_end1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
